result_framer: RTL and testbench
================================

RESULT_FRAMER -- requirements
Module: result_framer

Interface
REQ-001 SHALL have parameter NSINK, default 3, antenna blocks per complete block (1..255).
REQ-002 SHALL have parameter DWIDTH, default 32, data word width (>=16).
REQ-003 SHALL have parameter DEPTH, default 64, FIFO depth in words (power of two, >=4).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port sink_valid  input  1  input word valid; no backpressure on sink.
REQ-007 SHALL have ports sink_sop / sink_eop  input  1 each  first / last word of antenna packet.
REQ-008 SHALL have port sink_data  input  DWIDTH  payload word.
REQ-009 SHALL have port source_valid  output  1  output word valid.
REQ-010 SHALL have port source_ready  input  1  downstream accepts word.
REQ-011 SHALL have ports source_sop / source_eop  output  1 each  frame boundaries.
REQ-012 SHALL have port source_data  output  DWIDTH  framed word.
REQ-013 SHALL have port drop_count  output  16  dropped packets, saturating.

Function
REQ-014 SHALL frame each sink packet as: header {block_num[DWIDTH-9:0], antenna[7:0]}, then payload words in order.
REQ-015 SHALL implement write FSM IDLE -> PAYLOAD (sop) -> IDLE (eop); sop&eop same cycle = one-word packet; DROP entered on overflow, left on eop.
REQ-016 SHALL write the header in the sop cycle and each payload word one cycle after its arrival (one-word skid register).
REQ-017 SHALL require >=1 idle sink cycle after eop (>=2 with trailer); sop during the pending flush SHALL drop the new packet.
REQ-018 SHALL keep a tentative and a committed write pointer; commit at the write of the packet's final word.
REQ-019 SHALL expose only committed words to the read side (store-and-forward).
REQ-020 On FIFO full at any write: SHALL rewind tentative pointer to committed, enter DROP, discard until eop, increment drop_count.
REQ-021 sop while in PAYLOAD: SHALL abort the open packet (rewind, drop_count+1) and start the new one.
REQ-022 sink_eop or non-sop sink_valid in IDLE: SHALL be ignored.
REQ-023 Packets longer than DEPTH-2 words (DEPTH-3 with trailer) SHALL always drop.
REQ-024 antenna SHALL advance at every packet end (commit or drop), wrapping NSINK-1 -> 0; block_num increments on that wrap, modulo 2^(DWIDTH-8).
REQ-025 drop_count SHALL saturate at 16'hFFFF.
REQ-026 Read side SHALL be first-word-fall-through; source_* registered; word retired when source_valid && source_ready.
REQ-027 source_data/sop/eop SHALL hold stable while source_valid && !source_ready.
REQ-028 source_valid SHALL rise the cycle after commit when the output register is empty; sustained throughput one word/cycle.
REQ-029 Simultaneous read and write at full SHALL not overflow; full evaluated on pre-read occupancy.
REQ-030 source_sop SHALL mark header; source_eop SHALL mark last word of the frame.

Reset
REQ-031 Asserting reset SHALL immediately clear FSM to IDLE, all pointers, block_num, antenna, drop_count, source_valid, source_sop, source_eop and source_data to 0.
REQ-032 Reset mid-packet SHALL discard all FIFO contents, committed or not; no partial frame SHALL appear after release.
REQ-033 First packet after reset SHALL carry header block_num 0, antenna 0.

Configuration
REQ-034 Macro RESULT_FRAMER_TRAILER_EN defined: SHALL append trailer {drop_count snapshot[15:0], payload length[DWIDTH-17:0]} written the cycle after last payload word; trailer carries source_eop.
REQ-035 Macro undefined: no trailer; source_eop on last payload word; no trailer logic compiled.

Verification
REQ-036 After reset, NSINK=3, three 4-word packets (0xA0..0xA3 etc.), source_ready=1 -> headers 0x00000000, 0x00000001, 0x00000002, payloads in order, block_num 1 on fourth packet.
REQ-037 DEPTH=16, 20-word packet -> no output frame, drop_count=1, following 2-word packet framed with antenna 1.
REQ-038 source_ready toggled 1/0 every cycle during 8-word frame -> all 9 words exactly once, data stable while stalled.
REQ-039 sop at payload word 3 of open packet -> drop_count=1, only second packet emitted, antenna skips one value.
REQ-040 reset asserted with committed frame half-read -> source_valid 0 immediately; next frame header 0x00000000.
REQ-041 With RESULT_FRAMER_TRAILER_EN, 5-word packet after one drop -> trailer 0x00010005 with source_eop.

Source files
------------

// File: rtl/result_framer_if.sv
// Result framer bus: antenna-packet sink (no backpressure) and framed,
// ready/valid source side plus the saturating drop counter.
interface result_framer_if #(
    parameter int DWIDTH = 32
);
    logic              sink_valid;
    logic              sink_sop;
    logic              sink_eop;
    logic [DWIDTH-1:0] sink_data;
    logic              source_valid;
    logic              source_ready;
    logic              source_sop;
    logic              source_eop;
    logic [DWIDTH-1:0] source_data;
    logic [15:0]       drop_count;

    modport master (
        output sink_valid, sink_sop, sink_eop, sink_data, source_ready,
        input  source_valid, source_sop, source_eop, source_data, drop_count
    );

    modport slave (
        input  sink_valid, sink_sop, sink_eop, sink_data, source_ready,
        output source_valid, source_sop, source_eop, source_data, drop_count
    );
endinterface

// File: rtl/result_framer.sv
// Store-and-forward framer: prefixes each antenna packet with a {block_num, antenna}
// header and releases only fully committed frames. RESULT_FRAMER_TRAILER_EN adds a trailer.
module result_framer #(
    parameter int NSINK  = 3,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 64
) (
    input  logic           clk,
    input  logic           reset,
    result_framer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = DWIDTH - 8;
    localparam logic [AW-1:0] FULL_OCC = AW'(DEPTH - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PAYLOAD = 2'd1;
    localparam logic [1:0] S_DROP    = 2'd2;

    logic [1:0]          state, state_n;
    logic [AW-1:0]       wr_tent, wr_tent_n, wr_commit, wr_commit_n, rd_ptr;
    logic                skid_vld, skid_vld_n, skid_last, skid_last_n;
    logic [DWIDTH-1:0]   skid_data, skid_data_n;
    logic [BW+7:0]       pos, pos_n;
    logic [15:0]         drops, drops_n;
    logic                we, start, abort, pending;
    logic [AW-1:0]       waddr;
    logic [DWIDTH+1:0]   wword;
    logic                full_tent, full_commit, load;
    logic [DWIDTH+1:0]   mem [DEPTH];
`ifdef RESULT_FRAMER_TRAILER_EN
    localparam int LW = DWIDTH - 16;
    logic                trl_pend, trl_pend_n;
    logic [LW-1:0]       len, len_n;
`endif

    // pos packs {block_num, antenna}; antenna wraps at NSINK-1 and carries into block_num.
    function automatic logic [BW+7:0] bump(input logic [BW+7:0] p);
        if (p[7:0] == 8'(NSINK - 1))
            return {p[BW+7:8] + BW'(1), 8'd0};
        return {p[BW+7:8], p[7:0] + 8'd1};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // One slot is kept free, so a frame never exceeds DEPTH-1 words.
    assign full_tent   = ((wr_tent - rd_ptr) == FULL_OCC);
    assign full_commit = ((wr_commit - rd_ptr) == FULL_OCC);
    assign abort       = (state == S_PAYLOAD) && bus.sink_valid && bus.sink_sop;
`ifdef RESULT_FRAMER_TRAILER_EN
    assign pending     = skid_vld || trl_pend;
`else
    assign pending     = skid_vld;
`endif

    always_comb begin
        state_n     = state;
        wr_tent_n   = wr_tent;
        wr_commit_n = wr_commit;
        skid_vld_n  = 1'b0;
        skid_last_n = 1'b0;
        skid_data_n = skid_data;
        pos_n       = pos;
        drops_n     = drops;
        we          = 1'b0;
        waddr       = wr_tent;
        wword       = '0;
        start       = 1'b0;
`ifdef RESULT_FRAMER_TRAILER_EN
        trl_pend_n  = 1'b0;
        len_n       = len;
`endif

        // Write back the word captured last cycle; an abort throws it away instead.
        if (skid_vld && !abort) begin
            if (full_tent) begin
                wr_tent_n = wr_commit;
                drops_n   = sat_inc(drops_n);
                if (skid_last) pos_n = bump(pos_n);
                else           state_n = S_DROP;
            end else begin
                we        = 1'b1;
                wr_tent_n = wr_tent + AW'(1);
`ifdef RESULT_FRAMER_TRAILER_EN
                wword      = {2'b00, skid_data};
                trl_pend_n = skid_last;
`else
                wword = {1'b0, skid_last, skid_data};
                if (skid_last) begin
                    wr_commit_n = wr_tent + AW'(1);
                    pos_n       = bump(pos_n);
                end
`endif
            end
        end

`ifdef RESULT_FRAMER_TRAILER_EN
        if (trl_pend) begin
            wr_tent_n = wr_commit;
            pos_n     = bump(pos_n);
            if (full_tent) begin
                drops_n = sat_inc(drops_n);
            end else begin
                we          = 1'b1;
                wword       = {2'b01, drops, len};
                wr_tent_n   = wr_tent + AW'(1);
                wr_commit_n = wr_tent + AW'(1);
            end
        end
`endif

        if (bus.sink_valid) begin
            case (state)
                S_IDLE: begin
                    if (bus.sink_sop) begin
                        if (pending) begin
                            // Previous packet still flushing: the new one cannot be framed.
                            drops_n = sat_inc(drops_n);
                            if (bus.sink_eop) pos_n = bump(pos_n);
                            else              state_n = S_DROP;
                        end else begin
                            start = 1'b1;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (bus.sink_sop) begin
                        wr_tent_n = wr_commit;
                        drops_n   = sat_inc(drops_n);
                        pos_n     = bump(pos_n);
                        start     = 1'b1;
                    end else if (state_n == S_DROP) begin
                        if (bus.sink_eop) begin
                            state_n = S_IDLE;
                            pos_n   = bump(pos_n);
                        end
                    end else begin
                        skid_vld_n  = 1'b1;
                        skid_data_n = bus.sink_data;
                        skid_last_n = bus.sink_eop;
`ifdef RESULT_FRAMER_TRAILER_EN
                        len_n = len + LW'(1);
`endif
                        if (bus.sink_eop) state_n = S_IDLE;
                    end
                end
                S_DROP: begin
                    if (bus.sink_eop) begin
                        state_n = S_IDLE;
                        pos_n   = bump(pos_n);
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        // New packet: header goes in now, the sop word itself is the first payload word.
        if (start) begin
            if (full_commit) begin
                drops_n = sat_inc(drops_n);
                if (bus.sink_eop) begin
                    pos_n   = bump(pos_n);
                    state_n = S_IDLE;
                end else begin
                    state_n = S_DROP;
                end
            end else begin
                we          = 1'b1;
                waddr       = wr_commit;
                wword       = {2'b10, pos_n};
                wr_tent_n   = wr_commit + AW'(1);
                skid_vld_n  = 1'b1;
                skid_data_n = bus.sink_data;
                skid_last_n = bus.sink_eop;
`ifdef RESULT_FRAMER_TRAILER_EN
                len_n = LW'(1);
`endif
                state_n = bus.sink_eop ? S_IDLE : S_PAYLOAD;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            wr_tent   <= '0;
            wr_commit <= '0;
            skid_vld  <= 1'b0;
            skid_last <= 1'b0;
            skid_data <= '0;
            pos       <= '0;
            drops     <= '0;
`ifdef RESULT_FRAMER_TRAILER_EN
            trl_pend  <= 1'b0;
            len       <= '0;
`endif
        end else begin
            state     <= state_n;
            wr_tent   <= wr_tent_n;
            wr_commit <= wr_commit_n;
            skid_vld  <= skid_vld_n;
            skid_last <= skid_last_n;
            skid_data <= skid_data_n;
            pos       <= pos_n;
            drops     <= drops_n;
`ifdef RESULT_FRAMER_TRAILER_EN
            trl_pend  <= trl_pend_n;
            len       <= len_n;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wword;
    end

    // Looking at the next commit pointer lets a frame's header reach the output
    // register on the same edge that commits the frame.
    assign load = (wr_commit_n != rd_ptr) && (!bus.source_valid || bus.source_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr           <= '0;
            bus.source_valid <= 1'b0;
            bus.source_sop   <= 1'b0;
            bus.source_eop   <= 1'b0;
            bus.source_data  <= '0;
        end else if (load) begin
            rd_ptr           <= rd_ptr + AW'(1);
            bus.source_valid <= 1'b1;
            {bus.source_sop, bus.source_eop, bus.source_data} <= mem[rd_ptr];
        end else if (bus.source_ready) begin
            bus.source_valid <= 1'b0;
        end
    end

    assign bus.drop_count = drops;
endmodule

// File: tb/tb_result_framer.sv
// Randomised and directed bench for result_framer; expected frames come from a
// packet-level model (drop iff the frame cannot fit an empty FIFO).
module tb_result_framer;
    localparam int NSINK  = 3;
    localparam int DWIDTH = 32;
    localparam int DEPTH  = 16;
`ifdef RESULT_FRAMER_TRAILER_EN
    localparam int TRL = 1;
`else
    localparam int TRL = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    result_framer_if #(.DWIDTH(DWIDTH)) bus ();

    result_framer #(.NSINK(NSINK), .DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;
    int rdy_mode = 1;
    int m_ant = 0, m_blk = 0, m_drops = 0;
    logic [33:0] exp_q[$];
    logic [33:0] mon_obs, mon_exp, held;
    logic stalled = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void adv();
        if (m_ant == NSINK - 1) begin m_ant = 0; m_blk++; end
        else m_ant++;
    endfunction

    function automatic void m_drop();
        if (m_drops < 65535) m_drops++;
        adv();
    endfunction

    // Whole-packet reference: header, payload, optional trailer, or a drop.
    function automatic void m_frame(input int len, input logic [31:0] base);
        if (len + 1 + TRL > DEPTH - 1) begin m_drop(); return; end
        exp_q.push_back({2'b10, 32'(m_blk * 256 + m_ant)});
        for (int i = 0; i < len; i++)
            exp_q.push_back({1'b0, (TRL == 0 && i == len - 1), base + 32'(i)});
        if (TRL != 0) exp_q.push_back({2'b01, 32'(m_drops * 65536 + len)});
        adv();
    endfunction

    task automatic drive(input logic v, input logic s, input logic e, input logic [31:0] d);
        bus.sink_valid = v; bus.sink_sop = s; bus.sink_eop = e; bus.sink_data = d;
        @(posedge clk); #1;
    endtask

    task automatic send(input int len, input logic [31:0] base);
        for (int i = 0; i < len; i++) drive(1'b1, i == 0, i == len - 1, base + 32'(i));
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic pkt(input int len, input logic [31:0] base);
        m_frame(len, base);
        send(len, base);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
        check({tag, " drained"}, 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("valid on reset", bus.source_valid, 64'd0);
        exp_q.delete();
        m_ant = 0; m_blk = 0; m_drops = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // Ready pattern generator: 0 low, 1 high, 2 toggling, other random.
    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0:       bus.source_ready = 1'b0;
            1:       bus.source_ready = 1'b1;
            2:       bus.source_ready = ~bus.source_ready;
            default: bus.source_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        mon_obs = {bus.source_sop, bus.source_eop, bus.source_data};
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                vectors++;
                assert (bus.source_valid && mon_obs === held) else begin
                    miscompares++;
                    $error("FAIL hold: observed %0h (valid %0b) expected %0h", mon_obs, bus.source_valid, held);
                end
            end
            if (bus.source_valid && bus.source_ready) begin
                vectors++;
                assert (exp_q.size() != 0) else begin
                    miscompares++;
                    $error("FAIL extra word: observed %0h expected none", mon_obs);
                end
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    vectors++;
                    assert (mon_obs === mon_exp) else begin
                        miscompares++;
                        $error("FAIL word: observed %0h expected %0h", mon_obs, mon_exp);
                    end
                end
            end
            stalled = bus.source_valid && !bus.source_ready;
            held    = mon_obs;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int len, n;
        bus.sink_valid = 1'b0; bus.sink_sop = 1'b0; bus.sink_eop = 1'b0;
        bus.sink_data = '0; bus.source_ready = 1'b0;
        #2;
        do_reset();
        check("reset valid", bus.source_valid, 64'd0);
        check("reset sop", bus.source_sop, 64'd0);
        check("reset eop", bus.source_eop, 64'd0);
        check("reset data", bus.source_data, 64'd0);
        check("reset drops", bus.drop_count, 64'd0);

        // four packets: antenna 0,1,2 then block 1 antenna 0
        rdy_mode = 1;
        pkt(4, 32'hA0); pkt(4, 32'hB0); pkt(4, 32'hC0); pkt(4, 32'hD0);
        drain("four packets");

        // oversize packet drops, next packet takes antenna 1
        do_reset();
        pkt(20, 32'h100);
        check("drops oversize", bus.drop_count, 64'd1);
        pkt(2, 32'h200);
        drain("after oversize");

        rdy_mode = 2;
        pkt(8, 32'h300);
        drain("toggling ready");
        rdy_mode = 1;

        // sop on payload word 3 aborts the open packet
        do_reset();
        m_drop();
        drive(1'b1, 1'b1, 1'b0, 32'h400);
        drive(1'b1, 1'b0, 1'b0, 32'h401);
        drive(1'b1, 1'b0, 1'b0, 32'h402);
        pkt(4, 32'h500);
        check("drops abort", bus.drop_count, 64'd1);
        drain("abort");

        rdy_mode = 3;
        for (int k = 0; k < 40; k++) begin
            len = $urandom_range(1, 17);
            pkt(len, $urandom);
            drain("random");
        end
        check("drops random", bus.drop_count, 64'(m_drops));

        // reset with a committed frame half read
        rdy_mode = 0;
        pkt(8, 32'h600);
        n = 0;
        while (!bus.source_valid && n < 50) begin @(posedge clk); #1; n++; end
        check("frame pending", bus.source_valid, 64'd1);
        rdy_mode = 1;
        repeat (4) @(posedge clk);
        #1;
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check("drops after reset", bus.drop_count, 64'd0);
        rdy_mode = 1;
        pkt(3, 32'h700);
        drain("post reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
